// File: rtl/dst_post.sv
// dst_post: output post-processing stage between the matrix engine stream
// and the S2MM DMA.
//   - optional per-lane ReLU (sign bit set -> lane forced to zero)
//   - TLAST generation from a programmed frame length (beats minus 1)
//   - 2-entry skid buffer, registered s_ready, one beat per cycle
//
// Ports:
//   clk, reset (async, active-high), clr (sync clear)
//   relu_en, frame_len          : processing controls, sampled per input beat
//   s_valid/s_ready/s_data      : upstream stream
//   m_valid/m_ready/m_data/m_strb/m_last : downstream stream
//   frame_done                  : pulse the cycle after a last beat is accepted
//   beat_cnt                    : beats accepted downstream in current frame
//   neg_cnt (DST_POST_STAT_EN)  : negative lanes seen in accepted beats of
//                                 the current frame, held until the next frame
//
// Build option: define DST_POST_STAT_EN to add the neg_cnt statistic.
//
// Buffer states:
//   state    | meaning
//   ST_EMPTY | nothing held, s_ready=1, m_valid=0
//   ST_ONE   | main holds a beat, s_ready=1, m_valid=1
//   ST_FULL  | main and skid hold beats, s_ready=0, m_valid=1
module dst_post #(
   parameter int DW = 64,
   parameter int LW = 32,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clr,
   input  logic            relu_en,
   input  logic [CW-1:0]   frame_len,
   input  logic            s_valid,
   input  logic [DW-1:0]   s_data,
   output logic            s_ready,
   output logic            m_valid,
   output logic [DW-1:0]   m_data,
   output logic [DW/8-1:0] m_strb,
   output logic            m_last,
   input  logic            m_ready,
   output logic            frame_done,
   output logic [CW-1:0]   beat_cnt
`ifdef DST_POST_STAT_EN
   ,
   output logic [CW+1:0]   neg_cnt
`endif
);

   localparam int NL = DW / LW;
   localparam int NW = $clog2(NL + 1);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] main_data_q, main_data_d;
   logic          main_last_q, main_last_d;
   logic [DW-1:0] skid_data_q, skid_data_d;
   logic          skid_last_q, skid_last_d;
   logic [CW-1:0] in_cnt_q, in_cnt_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] beat_cnt_q, beat_cnt_d;
   logic          frame_done_q, frame_done_d;

   logic [DW-1:0] proc_data;
   logic [CW-1:0] cur_len;
   logic          in_last;
   logic          ready_int;
   logic          in_acc;
   logic          out_acc;

`ifdef DST_POST_STAT_EN
   logic [NW-1:0] in_neg;
   logic [NW-1:0] main_neg_q, main_neg_d;
   logic [NW-1:0] skid_neg_q, skid_neg_d;
   logic [CW+1:0] neg_cnt_q, neg_cnt_d;
`endif

   // s_ready depends only on the registered state; it is additionally
   // forced low while reset is asserted.
   assign ready_int  = (state_q != ST_FULL);
   assign s_ready    = ready_int & ~reset;
   assign m_valid    = (state_q != ST_EMPTY);
   assign m_data     = main_data_q;
   assign m_last     = main_last_q;
   assign m_strb     = '1;
   assign frame_done = frame_done_q;
   assign beat_cnt   = beat_cnt_q;

   assign in_acc  = s_valid & ready_int;
   assign out_acc = m_valid & m_ready;

   // ReLU on the sign bit works for both integer and float lanes.
   always_comb begin
      proc_data = s_data;
`ifdef DST_POST_STAT_EN
      in_neg = '0;
`endif
      for (int i = 0; i < NL; i++) begin
         if (s_data[LW*i+LW-1]) begin
`ifdef DST_POST_STAT_EN
            in_neg = in_neg + NW'(1);
`endif
            if (relu_en) proc_data[LW*i +: LW] = '0;
         end
      end
   end

   // The first beat of a frame compares against the live frame_len,
   // which is latched at the same time.
   assign cur_len = (in_cnt_q == '0) ? frame_len : len_q;
   assign in_last = (in_cnt_q == cur_len);

   always_comb begin
      state_d      = state_q;
      main_data_d  = main_data_q;
      main_last_d  = main_last_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      in_cnt_d     = in_cnt_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      frame_done_d = 1'b0;
`ifdef DST_POST_STAT_EN
      main_neg_d   = main_neg_q;
      skid_neg_d   = skid_neg_q;
      neg_cnt_d    = neg_cnt_q;
`endif

      if (clr) begin
         state_d     = ST_EMPTY;
         main_data_d = '0;
         main_last_d = 1'b0;
         skid_data_d = '0;
         skid_last_d = 1'b0;
         in_cnt_d    = '0;
         len_d       = '0;
         beat_cnt_d  = '0;
`ifdef DST_POST_STAT_EN
         main_neg_d  = '0;
         skid_neg_d  = '0;
         neg_cnt_d   = '0;
`endif
      end else begin
         if (in_acc) begin
            if (in_cnt_q == '0) len_d = frame_len;
            in_cnt_d = in_last ? '0 : in_cnt_q + CW'(1);
         end

         unique case (state_q)
            ST_EMPTY: begin
               if (s_valid) begin
                  main_data_d = proc_data;
                  main_last_d = in_last;
`ifdef DST_POST_STAT_EN
                  main_neg_d  = in_neg;
`endif
                  state_d     = ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_acc && !out_acc) begin
                  skid_data_d = proc_data;
                  skid_last_d = in_last;
`ifdef DST_POST_STAT_EN
                  skid_neg_d  = in_neg;
`endif
                  state_d     = ST_FULL;
               end else if (!in_acc && out_acc) begin
                  state_d     = ST_EMPTY;
               end else if (in_acc && out_acc) begin
                  main_data_d = proc_data;
                  main_last_d = in_last;
`ifdef DST_POST_STAT_EN
                  main_neg_d  = in_neg;
`endif
               end
            end
            ST_FULL: begin
               if (m_ready) begin
                  main_data_d = skid_data_q;
                  main_last_d = skid_last_q;
`ifdef DST_POST_STAT_EN
                  main_neg_d  = skid_neg_q;
`endif
                  state_d     = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase

         if (out_acc) begin
            beat_cnt_d   = main_last_q ? '0 : beat_cnt_q + CW'(1);
            frame_done_d = main_last_q;
`ifdef DST_POST_STAT_EN
            // A zero beat count marks the first beat of a frame: restart
            // the tally there so the previous total is held until then.
            if (beat_cnt_q == '0) neg_cnt_d = (CW+2)'(main_neg_q);
            else                  neg_cnt_d = neg_cnt_q + (CW+2)'(main_neg_q);
`endif
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_EMPTY;
         main_data_q  <= '0;
         main_last_q  <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         in_cnt_q     <= '0;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         frame_done_q <= 1'b0;
`ifdef DST_POST_STAT_EN
         main_neg_q   <= '0;
         skid_neg_q   <= '0;
         neg_cnt_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         main_data_q  <= main_data_d;
         main_last_q  <= main_last_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         in_cnt_q     <= in_cnt_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         frame_done_q <= frame_done_d;
`ifdef DST_POST_STAT_EN
         main_neg_q   <= main_neg_d;
         skid_neg_q   <= skid_neg_d;
         neg_cnt_q    <= neg_cnt_d;
`endif
      end
   end

`ifdef DST_POST_STAT_EN
   assign neg_cnt = neg_cnt_q;
`endif

endmodule
